// File: rtl/fetch_unit_pkg.sv
// Shared constants for the IF stage and ID decode: pc_src encodings, bubble pattern, opcodes.
package fetch_unit_pkg;

  localparam int unsigned PC_W_DEF      = 16;
  localparam int unsigned INSTR_W_DEF   = 16;
  localparam int unsigned RAS_DEPTH_DEF = 4;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'd0,
    PCSRC_JMP = 2'd1,
    PCSRC_BR  = 2'd2,
    PCSRC_RET = 2'd3
  } pc_src_e;

  // Opcode field (instr[15:12]) values shared with ID decode
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_BLT  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Circular return-address stack: pushes past full overwrite the oldest entry, count saturates.
module return_stack #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;

  assign top   = mem[top_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push) begin
      top_ptr <= top_ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - PTR_W'(1);
      count   <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; entries are only read once count says they are valid
  always_ff @(posedge clk) begin
    if (!reset && push) mem[top_ptr + PTR_W'(1)] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, instruction-memory address, IF/ID register, RET target select.
// Optional return-address stack enabled by defining RAS_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          PC_W      = 16,
  parameter int unsigned          INSTR_W   = 16,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(fetch_unit_pkg::NOP_INSTR),
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               kill,
  input  logic [1:0]         pc_src,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    ret_target,
  input  logic               id_is_call,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus1,
  output logic               if_id_valid,
  output logic               ras_underflow
);

  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] ret_sel;
  logic [PC_W-1:0] next_pc;
  logic            redirect;
  logic            underflow_next;

  assign imem_addr = pc;
  assign pc_plus1  = pc + PC_W'(1);
  assign redirect  = (pc_src != PCSRC_SEQ);

`ifdef RAS_EN
  logic            ras_push;
  logic            ras_pop;
  logic            ras_empty;
  logic            unused_ras_full;
  logic [PC_W-1:0] ras_top;

  assign ras_push = !stall && (pc_src == PCSRC_JMP) && id_is_call;
  assign ras_pop  = !stall && (pc_src == PCSRC_RET);

  return_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (if_id_pc_plus1),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (unused_ras_full)
  );

  // Empty stack falls back to the register-read target
  assign ret_sel        = ras_empty ? ret_target : ras_top;
  assign underflow_next = ras_pop && ras_empty;
`else
  logic unused_ras;

  assign unused_ras     = ^{id_is_call, RAS_DEPTH[0]};
  assign ret_sel        = ret_target;
  assign underflow_next = 1'b0;
`endif

  always_comb begin
    next_pc = pc_plus1;
    case (pc_src)
      PCSRC_JMP: next_pc = jump_target;
      PCSRC_BR:  next_pc = branch_target;
      PCSRC_RET: next_pc = ret_sel;
      default:   next_pc = pc_plus1;
    endcase
  end

  // Stall freezes everything; the redirecting instruction re-presents pc_src afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
      ras_underflow  <= 1'b0;
    end else begin
      ras_underflow <= 1'b0;
      if (!stall) begin
        pc            <= next_pc;
        ras_underflow <= underflow_next;
        if (redirect || kill) begin
          if_id_instr    <= NOP_INSTR;
          if_id_pc_plus1 <= '0;
          if_id_valid    <= 1'b0;
        end else begin
          if_id_instr    <= imem_data;
          if_id_pc_plus1 <= pc_plus1;
          if_id_valid    <= 1'b1;
        end
      end
    end
  end

endmodule
